// File: rtl/btn_step_debouncer.sv
// Push-button conditioner: synchronises btn_raw, debounces press and release,
// and emits one-cycle step pulses (one per accepted press plus auto-repeats).
module btn_step_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic step_pulse,
    output logic btn_level,
    output logic repeat_active
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_ZERO         = DB_W'(0);
    localparam logic [DB_W-1:0]  DB_ONE          = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ZERO        = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
    localparam logic [REP_W-1:0] REP_MAX_V       = REP_W'(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam bit               DB_SINGLE       = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   btn_s;

    state_t                 state_q;
    state_t                 state_d;
    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic [REP_W-1:0]       rep_cnt_q;
    logic [REP_W-1:0]       rep_cnt_d;
    logic [REP_W-1:0]       rep_last_s;
    logic                   step_pulse_q;
    logic                   step_pulse_d;
    logic                   btn_level_q;
    logic                   btn_level_d;
    logic                   repeat_active_q;
    logic                   repeat_active_d;

    // Synchroniser shift chain; only the last stage feeds the FSM.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Next-state, counter and output logic of the debounce/repeat FSM.
    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        rep_cnt_d       = rep_cnt_q;
        step_pulse_d    = 1'b0;
        btn_level_d     = btn_level_q;
        repeat_active_d = repeat_active_q;
        rep_last_s      = repeat_active_q ? REP_PERIOD_LAST : REP_DELAY_LAST;

        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    if (DB_SINGLE) begin
                        state_d      = HELD;
                        db_cnt_d     = DB_ZERO;
                        rep_cnt_d    = REP_ZERO;
                        step_pulse_d = 1'b1;
                        btn_level_d  = 1'b1;
                    end else begin
                        state_d  = PRESS_DEB;
                        db_cnt_d = DB_ONE;
                    end
                end else begin
                    db_cnt_d = DB_ZERO;
                end
            end

            PRESS_DEB: begin
                if (!btn_s) begin
                    state_d  = RELEASED;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d      = HELD;
                    db_cnt_d     = DB_ZERO;
                    rep_cnt_d    = REP_ZERO;
                    step_pulse_d = 1'b1;
                    btn_level_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            HELD: begin
                // A pulse is deferred by one cycle if the previous cycle already pulsed.
                if (!repeat_en) begin
                    rep_cnt_d       = REP_ZERO;
                    repeat_active_d = 1'b0;
                end else if (btn_s) begin
                    if ((rep_cnt_q >= rep_last_s) && !step_pulse_q) begin
                        rep_cnt_d       = REP_ZERO;
                        step_pulse_d    = 1'b1;
                        repeat_active_d = 1'b1;
                    end else if (rep_cnt_q < REP_MAX_V) begin
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                    end else begin
                        rep_cnt_d = rep_cnt_q;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q;
                end

                if (!btn_s) begin
                    state_d  = RELEASE_DEB;
                    db_cnt_d = DB_ONE;
                end else begin
                    db_cnt_d = DB_ZERO;
                end
            end

            RELEASE_DEB: begin
                if (btn_s) begin
                    state_d  = HELD;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d         = RELEASED;
                    db_cnt_d        = DB_ZERO;
                    btn_level_d     = 1'b0;
                    repeat_active_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d         = RELEASED;
                db_cnt_d        = DB_ZERO;
                rep_cnt_d       = REP_ZERO;
                btn_level_d     = 1'b0;
                repeat_active_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= {SYNC_STAGES{1'b0}};
            state_q         <= RELEASED;
            db_cnt_q        <= DB_ZERO;
            rep_cnt_q       <= REP_ZERO;
            step_pulse_q    <= 1'b0;
            btn_level_q     <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
            step_pulse_q    <= step_pulse_d;
            btn_level_q     <= btn_level_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    assign step_pulse    = step_pulse_q;
    assign btn_level     = btn_level_q;
    assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_btn_step_debouncer.sv
// Bench for btn_step_debouncer: directed scenarios with fixed expected edges,
// then randomized traffic checked cycle-by-cycle against a run-length model.
module tb_btn_step_debouncer;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic repeat_en;
    logic step_pulse;
    logic btn_level;
    logic repeat_active;

    int n_cmp;
    int n_err;
    int cyc;
    int a_edge;
    int pulse_log[$];

    // Reference model: sampled-button history, run length toward the other level,
    // enabled-hold time since the last pulse.
    bit m_sync [S];
    bit m_level;
    int m_run;
    int m_rep;
    bit m_ract;
    bit m_pulse;

    btn_step_debouncer #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .step_pulse(step_pulse), .btn_level(btn_level), .repeat_active(repeat_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
        m_level = 1'b0; m_run = 0; m_rep = 0; m_ract = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic void model_edge(bit raw, bit en);
        bit b;
        bit p;
        int tgt;
        b = m_sync[S-1];
        p = 1'b0;
        if (!m_level) begin
            m_run = b ? m_run + 1 : 0;
            if (m_run >= D) begin
                m_level = 1'b1; m_run = 0; m_rep = 0; p = 1'b1;
            end
        end else if (m_run == 0) begin
            if (!en) begin
                m_rep = 0; m_ract = 1'b0;
            end else if (b) begin
                m_rep++;
                tgt = m_ract ? RP : RD;
                if (m_rep >= tgt && !m_pulse) begin
                    p = 1'b1; m_ract = 1'b1; m_rep = 0;
                end
            end
            if (!b) m_run = 1;
        end else begin
            if (b) m_run = 0;
            else begin
                m_run++;
                if (m_run >= D) begin
                    m_level = 1'b0; m_run = 0; m_ract = 1'b0;
                end
            end
        end
        m_pulse = p;
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw;
    endfunction

    task automatic tick(input bit raw, input bit en);
        btn_raw   = raw;
        repeat_en = en;
        @(posedge clk);
        model_edge(raw, en);
        #1;
        cyc++;
        if (step_pulse === 1'b1) pulse_log.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_raw = 1'b0; repeat_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({step_pulse, btn_level, repeat_active} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000", {step_pulse, btn_level, repeat_active});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int e0;
        idle(10);
        pulse_log.delete();
        e0 = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0);
            if (k == 4 || k == 5) begin
                n_cmp++;
                if (btn_level !== 1'(k == 5)) begin
                    n_err++;
                    $display("FAIL press_level k=%0d: got %b expected %b", k, btn_level, (k == 5));
                end
            end
        end
        n_cmp++;
        if (pulse_log.size() != 1) begin
            n_err++;
            $display("FAIL press_count: got %0d expected 1", pulse_log.size());
        end else begin
            n_cmp++;
            if (pulse_log[0] != e0 + 5) begin
                n_err++;
                $display("FAIL press_edge: got %0d expected %0d", pulse_log[0], e0 + 5);
            end
        end
        idle(12);
    endtask

    task automatic test_bounce();
        int s;
        bit raw;
        int p;
        pulse_log.delete();
        for (int i = 0; i < 49; i++) begin
            p   = i % 7;
            raw = (p < 2) || (p >= 3 && p <= 5);
            tick(raw, 1'b0);
        end
        n_cmp++;
        if (pulse_log.size() != 0) begin
            n_err++;
            $display("FAIL bounce_quiet: got %0d pulses expected 0", pulse_log.size());
        end
        s = cyc + 1;
        repeat (10) tick(1'b1, 1'b0);
        n_cmp++;
        if (pulse_log.size() != 1 || pulse_log[0] != s + 5) begin
            n_err++;
            $display("FAIL bounce_accept: got %0d pulses first=%0d expected 1 at %0d",
                     pulse_log.size(), (pulse_log.size() > 0) ? pulse_log[0] : -1, s + 5);
        end
        idle(12);
    endtask

    task automatic test_repeat_hold();
        int e0;
        int exp_q[$];
        pulse_log.delete();
        e0 = cyc + 1;
        repeat (6) tick(1'b1, 1'b1);
        a_edge = e0 + 5;
        for (int k = 1; k <= 52; k++) begin
            tick(1'b1, 1'b1);
            if (k == 19 || k == 20) begin
                n_cmp++;
                if (repeat_active !== 1'(k == 20)) begin
                    n_err++;
                    $display("FAIL repeat_active k=%0d: got %b expected %b", k, repeat_active, (k == 20));
                end
            end
        end
        exp_q = '{a_edge, a_edge + 20, a_edge + 28, a_edge + 36, a_edge + 44, a_edge + 52};
        n_cmp++;
        if (pulse_log.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL repeat_count: got %0d expected %0d", pulse_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (pulse_log[i] != exp_q[i]) begin
                    n_err++;
                    $display("FAIL repeat_edge[%0d]: got %0d expected %0d", i, pulse_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_release_bounce();
        pulse_log.delete();
        for (int k = 0; k < 11; k++) begin
            tick(1'(k == 2), 1'b1);
            if (k == 7 || k == 8) begin
                n_cmp++;
                if ({btn_level, repeat_active} !== {2{1'(k == 7)}}) begin
                    n_err++;
                    $display("FAIL release_fall k=%0d: got %b%b expected %b%b", k,
                             btn_level, repeat_active, (k == 7), (k == 7));
                end
            end
        end
        n_cmp++;
        if (pulse_log.size() != 0) begin
            n_err++;
            $display("FAIL release_quiet: got %0d pulses expected 0", pulse_log.size());
        end
        idle(6);
    endtask

    task automatic test_reset_mid_press();
        int e0;
        idle(10);
        repeat (4) tick(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({step_pulse, btn_level, repeat_active} !== 3'b000) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b expected 000", {step_pulse, btn_level, repeat_active});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulse_log.delete();
        e0 = cyc + 1;
        repeat (8) tick(1'b1, 1'b0);
        n_cmp++;
        if (pulse_log.size() != 1 || pulse_log[0] != e0 + 5) begin
            n_err++;
            $display("FAIL midreset_repress: got %0d pulses first=%0d expected 1 at %0d",
                     pulse_log.size(), (pulse_log.size() > 0) ? pulse_log[0] : -1, e0 + 5);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL heldreset_level: got %b expected 0", btn_level);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
    endtask

    task automatic test_repeat_toggle();
        int e;
        int exp_q[$];
        idle(6);
        repeat (6) tick(1'b1, 1'b1);
        pulse_log.delete();
        repeat (10) tick(1'b1, 1'b1);
        repeat (15) tick(1'b1, 1'b0);
        e = cyc + 1;
        repeat (40) tick(1'b1, 1'b1);
        exp_q = '{e + 19, e + 27, e + 35};
        n_cmp++;
        if (pulse_log.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL toggle_count: got %0d expected %0d", pulse_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (pulse_log[i] != exp_q[i]) begin
                    n_err++;
                    $display("FAIL toggle_edge[%0d]: got %0d expected %0d", i, pulse_log[i], exp_q[i]);
                end
            end
        end
        idle(12);
    endtask

    task automatic test_random();
        bit raw;
        bit en;
        int left;
        raw = 1'b0; en = 1'b1; left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                raw  = ~raw;
                left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 70));
                if ($urandom_range(0, 9) == 0) en = ~en;
            end
            left--;
            tick(raw, en);
            n_cmp++;
            if ({step_pulse, btn_level, repeat_active} !== {m_pulse, m_level, m_ract}) begin
                n_err++;
                $display("FAIL random_cmp cyc=%0d: got %b expected %b", cyc,
                         {step_pulse, btn_level, repeat_active}, {m_pulse, m_level, m_ract});
            end
            if ($urandom_range(0, 699) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({step_pulse, btn_level, repeat_active} !== 3'b000) begin
                    n_err++;
                    $display("FAIL random_reset: got %b expected 000", {step_pulse, btn_level, repeat_active});
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; a_edge = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat_hold();
        test_release_bounce();
        test_reset_mid_press();
        test_repeat_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
